// File: rtl/pad_pkg.sv
// Shared types and elaboration helpers for the output pad bank.
package pad_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } pad_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Bits needed to hold a group count in the range 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pad_ssn_limiter.sv
// Picks at most MAX_TOGGLE set bits of diff, lowest index first.
module pad_ssn_limiter
    import pad_pkg::*;
#(
    parameter int W          = 8,
    parameter int MAX_TOGGLE = 2
) (
    input  logic [W-1:0] diff,
    output logic [W-1:0] sel
);

    always_comb begin
        int budget;
        budget = 0;
        sel    = '0;
        for (int k = 0; k < W; k++) begin
            if (diff[k] && (budget < MAX_TOGGLE)) begin
                sel[k] = 1'b1;
                budget = budget + 1;
            end
        end
    end

endmodule

// File: rtl/pad_out_bank.sv
// Output pad bank with staggered group enable/disable and deferred drive-strength loads.
// Define PAD_SSN_LIMIT_EN to cap the number of PAD bits switching per cycle at MAX_TOGGLE.
//
// state     | meaning
// OFF       | all pads disabled, drive-strength loads apply directly
// RAMP_UP   | enabling one group every STEP_CYCLES
// ON        | all pads enabled, ready asserted
// RAMP_DOWN | disabling one group every STEP_CYCLES, highest first
module pad_out_bank
    import pad_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int GROUP       = 2,
    parameter int STEP_CYCLES = 4,
    parameter int DRIVE_W     = 2,
    parameter int MAX_TOGGLE  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] I,
    input  logic                en_req,
    input  logic [DRIVE_W-1:0]  ds_in,
    input  logic                ds_load,
    output logic [CHANNELS-1:0] PAD,
    output logic [CHANNELS-1:0] PAD_OE,
    output logic [DRIVE_W-1:0]  PAD_DS,
    output logic                ready,
    output logic                busy
);

    localparam int G  = ceil_div(CHANNELS, GROUP);
    localparam int GW = cnt_width(G);
    localparam int TW = (STEP_CYCLES <= 1) ? 1 : $clog2(STEP_CYCLES);
    localparam logic [GW-1:0] G_ALL    = GW'(G);
    localparam logic [TW-1:0] T_RELOAD = TW'(STEP_CYCLES - 1);

    if (CHANNELS < 1 || CHANNELS > 64 || GROUP < 1 || GROUP > CHANNELS ||
        STEP_CYCLES < 1 || DRIVE_W < 1 || MAX_TOGGLE < 1) begin : g_param_check
        $error("pad_out_bank: parameter out of range");
    end

    pad_state_e          state_q, state_d;
    logic [GW-1:0]       grp_cnt_q, grp_cnt_d;
    logic [TW-1:0]       tmr_q, tmr_d;
    logic [CHANNELS-1:0] oe_q, oe_d;
    logic [CHANNELS-1:0] pad_q, pad_d;
    logic [DRIVE_W-1:0]  ds_q, ds_d;
    logic [DRIVE_W-1:0]  ds_pend_q, ds_pend_d;
    logic                ds_pend_vld_q, ds_pend_vld_d;
    logic [CHANNELS-1:0] pad_target;

    always_comb begin
        state_d       = state_q;
        grp_cnt_d     = grp_cnt_q;
        tmr_d         = tmr_q;
        ds_d          = ds_q;
        ds_pend_d     = ds_pend_q;
        ds_pend_vld_d = ds_pend_vld_q;
        oe_d          = '0;

        case (state_q)
            OFF: begin
                if (en_req) begin
                    state_d   = RAMP_UP;
                    grp_cnt_d = GW'(1);
                    tmr_d     = T_RELOAD;
                end
            end
            RAMP_UP: begin
                if (!en_req) begin
                    state_d = RAMP_DOWN;
                    tmr_d   = T_RELOAD;
                end else if (grp_cnt_q == G_ALL) begin
                    state_d = ON;
                end else if (tmr_q == '0) begin
                    grp_cnt_d = grp_cnt_q + GW'(1);
                    tmr_d     = T_RELOAD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ON: begin
                if (!en_req) begin
                    state_d   = RAMP_DOWN;
                    grp_cnt_d = grp_cnt_q - GW'(1);
                    tmr_d     = T_RELOAD;
                end
            end
            RAMP_DOWN: begin
                if (en_req) begin
                    state_d = RAMP_UP;
                    tmr_d   = T_RELOAD;
                end else if (grp_cnt_q == '0) begin
                    state_d = OFF;
                end else if (tmr_q == '0) begin
                    grp_cnt_d = grp_cnt_q - GW'(1);
                    tmr_d     = T_RELOAD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: state_d = OFF;
        endcase

        for (int k = 0; k < CHANNELS; k++) begin
            oe_d[k] = (k < int'(grp_cnt_d) * GROUP);
        end

        // Loads during a ramp are parked and released on the edge that settles the bank.
        if (state_q == OFF || state_q == ON) begin
            if (ds_load) begin
                ds_d = ds_in;
            end
        end else begin
            if (ds_load) begin
                ds_pend_d     = ds_in;
                ds_pend_vld_d = 1'b1;
            end
            if ((state_d == ON || state_d == OFF) && ds_pend_vld_d) begin
                ds_d          = ds_pend_d;
                ds_pend_vld_d = 1'b0;
            end
        end
    end

    assign pad_target = oe_q & I;

`ifdef PAD_SSN_LIMIT_EN
    logic [CHANNELS-1:0] toggle_sel;

    pad_ssn_limiter #(
        .W          (CHANNELS),
        .MAX_TOGGLE (MAX_TOGGLE)
    ) u_ssn_limiter (
        .diff (pad_q ^ pad_target),
        .sel  (toggle_sel)
    );

    assign pad_d = pad_q ^ toggle_sel;
`else
    assign pad_d = pad_target;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= OFF;
            grp_cnt_q     <= '0;
            tmr_q         <= '0;
            oe_q          <= '0;
            pad_q         <= '0;
            ds_q          <= '0;
            ds_pend_q     <= '0;
            ds_pend_vld_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            grp_cnt_q     <= grp_cnt_d;
            tmr_q         <= tmr_d;
            oe_q          <= oe_d;
            pad_q         <= pad_d;
            ds_q          <= ds_d;
            ds_pend_q     <= ds_pend_d;
            ds_pend_vld_q <= ds_pend_vld_d;
        end
    end

    assign PAD    = pad_q;
    assign PAD_OE = oe_q;
    assign PAD_DS = ds_q;
    assign ready  = (state_q == ON);
    assign busy   = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: tb/tb_pad_out_bank.sv
// Scoreboard bench for pad_out_bank at default parameters (8 channels, groups of 2, 4-cycle steps).
module tb_pad_out_bank;

    localparam int CH   = 8;
    localparam int GRP  = 2;
    localparam int STEP = 4;
    localparam int DW   = 2;
    localparam int MAXT = 2;
    localparam int NG   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] I;
    logic          en_req;
    logic [DW-1:0] ds_in;
    logic          ds_load;
    logic [CH-1:0] PAD;
    logic [CH-1:0] PAD_OE;
    logic [DW-1:0] PAD_DS;
    logic          ready;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [CH-1:0] pad;
        logic [CH-1:0] oe;
        logic [DW-1:0] ds;
        logic          rdy;
        logic          bsy;
    } exp_t;

    exp_t sb[$];

    // Reference model state: mode 0=off 1=up 2=on 3=down, groups enabled, cycles waited in step.
    int            m_mode, m_groups, m_wait;
    logic [CH-1:0] m_pad, m_oe;
    logic [DW-1:0] m_ds, m_pend;
    logic          m_pend_v;

    always #5 clk = ~clk;

    pad_out_bank #(
        .CHANNELS    (CH),
        .GROUP       (GRP),
        .STEP_CYCLES (STEP),
        .DRIVE_W     (DW),
        .MAX_TOGGLE  (MAXT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .I       (I),
        .en_req  (en_req),
        .ds_in   (ds_in),
        .ds_load (ds_load),
        .PAD     (PAD),
        .PAD_OE  (PAD_OE),
        .PAD_DS  (PAD_DS),
        .ready   (ready),
        .busy    (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_groups = 0; m_wait = 0;
        m_pad = '0; m_oe = '0; m_ds = '0; m_pend = '0; m_pend_v = 1'b0;
    endtask

    function automatic logic [CH-1:0] groups_to_oe(input int g);
        logic [CH:0] t;
        t = ({{CH{1'b0}}, 1'b1} << (g * GRP)) - 1;
        return t[CH-1:0];
    endfunction

    function automatic logic [CH-1:0] ssn_step(input logic [CH-1:0] cur, input logic [CH-1:0] tgt);
        logic [CH-1:0] res;
        int n;
        res = cur;
        n = 0;
        for (int i = 0; i < CH; i++) begin
            if (cur[i] != tgt[i] && n < MAXT) begin
                res[i] = tgt[i];
                n++;
            end
        end
        return res;
    endfunction

    // Predict the post-edge outputs from the present inputs, push them, then compare after the edge.
    task automatic tick();
        exp_t e, g;
        int nm, ng, nw;
        nm = m_mode; ng = m_groups; nw = m_wait;
        case (m_mode)
            0: if (en_req) begin nm = 1; ng = 1; nw = 0; end
            1: if (!en_req) begin nm = 3; nw = 0; end
               else if (m_groups == NG) nm = 2;
               else if (m_wait == STEP - 1) begin ng = m_groups + 1; nw = 0; end
               else nw = m_wait + 1;
            2: if (!en_req) begin nm = 3; ng = m_groups - 1; nw = 0; end
            default: if (en_req) begin nm = 1; nw = 0; end
               else if (m_groups == 0) nm = 0;
               else if (m_wait == STEP - 1) begin ng = m_groups - 1; nw = 0; end
               else nw = m_wait + 1;
        endcase
        e.ds = m_ds;
        if (m_mode == 0 || m_mode == 2) begin
            if (ds_load) e.ds = ds_in;
        end else begin
            if (ds_load) begin m_pend = ds_in; m_pend_v = 1'b1; end
            if ((nm == 0 || nm == 2) && m_pend_v) begin e.ds = m_pend; m_pend_v = 1'b0; end
        end
`ifdef PAD_SSN_LIMIT_EN
        e.pad = ssn_step(m_pad, m_oe & I);
`else
        e.pad = m_oe & I;
`endif
        e.oe  = groups_to_oe(ng);
        e.rdy = (nm == 2);
        e.bsy = (nm == 1 || nm == 3);
        sb.push_back(e);
        m_mode = nm; m_groups = ng; m_wait = nw;
        m_pad = e.pad; m_oe = e.oe; m_ds = e.ds;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check("pad", PAD, g.pad);
        check("oe", PAD_OE, g.oe);
        check("ds", PAD_DS, g.ds);
        check("ready", ready, g.rdy);
        check("busy", busy, g.bsy);
    endtask

    initial begin
        logic found, saw3f, saw03;
        rst = 1'b1; I = '0; en_req = 1'b0; ds_in = '0; ds_load = 1'b0;
        model_reset();
        #2;
        check("rst_pad", PAD, 8'h00);
        check("rst_oe", PAD_OE, 8'h00);
        check("rst_ds", PAD_DS, 2'b00);
        check("rst_ready", ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();

        // Ramp up with a drive-strength load parked mid-ramp.
        I = 8'hA5; en_req = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            case (e)
                1:  check("up_oe_e1", PAD_OE, 8'h03);
                2:  begin check("up_busy_e2", busy, 1'b1); ds_in = 2'b11; ds_load = 1'b1; end
                3:  begin ds_load = 1'b0; ds_in = 2'b00; end
                4:  check("up_oe_e4", PAD_OE, 8'h03);
                5:  check("up_oe_e5", PAD_OE, 8'h0F);
                9:  check("up_oe_e9", PAD_OE, 8'h3F);
                13: begin
                    check("up_oe_e13", PAD_OE, 8'hFF);
                    check("up_ready_e13", ready, 1'b0);
                    check("up_ds_e13", PAD_DS, 2'b00);
                end
                14: begin
                    check("up_ready_e14", ready, 1'b1);
                    check("up_busy_e14", busy, 1'b0);
                    check("up_ds_e14", PAD_DS, 2'b11);
                end
                default: ;
            endcase
        end

        // Data path while ON, plus a direct drive-strength load.
        for (int i = 0; i < 10; i++) begin
            I = CH'($urandom);
            tick();
        end
        ds_in = 2'b01; ds_load = 1'b1; tick();
        ds_load = 1'b0; ds_in = 2'b10; tick();
        check("on_ds_direct", PAD_DS, 2'b01);

        // Ramp down from ON.
        en_req = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            case (e)
                1:  begin check("dn_oe_e1", PAD_OE, 8'h3F); check("dn_ready_e1", ready, 1'b0); end
                5:  check("dn_oe_e5", PAD_OE, 8'h0F);
                9:  check("dn_oe_e9", PAD_OE, 8'h03);
                13: check("dn_oe_e13", PAD_OE, 8'h00);
                14: begin check("dn_busy_e14", busy, 1'b0); check("dn_pad_e14", PAD, 8'h00); end
                default: ;
            endcase
        end

        // Reversal at 0x0F, with two parked loads (the later one must win).
        en_req = 1'b1; I = 8'hFF; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (PAD_OE == 8'h0F) found = 1'b1;
        end
        check("rev_reach_0f", found, 1'b1);
        en_req = 1'b0; saw3f = 1'b0; saw03 = 1'b0;
        ds_in = 2'b01; ds_load = 1'b1; tick();
        ds_in = 2'b10; tick();
        ds_load = 1'b0; ds_in = 2'b00;
        for (int i = 0; i < 60 && busy; i++) begin
            if (PAD_OE == 8'h3F) saw3f = 1'b1;
            if (PAD_OE == 8'h03) saw03 = 1'b1;
            if (busy) tick();
        end
        check("rev_settled", busy, 1'b0);
        check("rev_no_3f", saw3f, 1'b0);
        check("rev_saw_03", saw03, 1'b1);
        check("rev_pend_ds", PAD_DS, 2'b10);

        // Asynchronous reset in the middle of a ramp.
        en_req = 1'b1; I = 8'h5A;
        for (int e = 1; e <= 9; e++) tick();
        check("pre_rst_oe", PAD_OE, 8'h3F);
        #1 rst = 1'b1;
        #1;
        check("arst_oe", PAD_OE, 8'h00);
        check("arst_pad", PAD, 8'h00);
        check("arst_ready", ready, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_ds", PAD_DS, 2'b00);
        model_reset();
        en_req = 1'b0;
        #1 rst = 1'b0;
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(11, 0) == 0) en_req = ~en_req;
            I = CH'($urandom);
            ds_in = DW'($urandom);
            ds_load = ($urandom_range(4, 0) == 0);
            tick();
        end
        ds_load = 1'b0;

`ifdef PAD_SSN_LIMIT_EN
        en_req = 1'b1; I = 8'h00;
        for (int i = 0; i < 80 && !ready; i++) tick();
        check("ssn_on", ready, 1'b1);
        tick(); tick();
        check("ssn_pad0", PAD, 8'h00);
        I = 8'hFF;
        tick(); check("ssn_e1", PAD, 8'h03);
        tick(); check("ssn_e2", PAD, 8'h0F);
        tick(); check("ssn_e3", PAD, 8'h3F);
        tick(); check("ssn_e4", PAD, 8'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
